// File: rtl/data_mem_responder.sv
// data_mem_responder
//   Data-memory responder between the datapath and a word-organised RAM.
//   Accepts one load or store per request, holds the core with `stall` for a
//   fixed latency, then completes the access. Load data is registered.
//
//   Optional feature: define MISALIGN_TRAP_EN to trap accesses whose
//   addr[1:0] != 0. A trapped store does not write, a trapped load returns 0,
//   and err pulses with ready.
//
// Ports
//   clk       in   1            rising-edge clock
//   rst       in   1            synchronous active-high reset
//   memread   in   1            load request
//   memwrite  in   1            store request (wins over memread)
//   addr      in   32           byte address; word index = addr[ADDR_WIDTH+1:2]
//   wdata     in   DATA_WIDTH   store data
//   rdata     out  DATA_WIDTH   load data, registered, held until next load
//   stall     out  1            core must hold PC and request inputs
//   ready     out  1            completion pulse
//   err       out  1            completion pulse of an illegal request
module data_mem_responder #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32,
  parameter int LATENCY    = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  memread,
  input  logic                  memwrite,
  input  logic [31:0]           addr,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  stall,
  output logic                  ready,
  output logic                  err
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t                state_reg, state_next;
  logic [3:0]            cnt_reg, cnt_next;
  logic [ADDR_WIDTH-1:0] idx_reg;
  logic [DATA_WIDTH-1:0] wdata_reg;
  logic                  store_reg;
  logic                  err_reg;
  logic                  mis_reg;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic                  req;
  logic                  req_mis;
  logic [ADDR_WIDTH-1:0] rd_idx;
  logic                  rd_load;
  logic                  rd_mis;

  // Address bits that never select a word; collected so they are visibly consumed.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{addr[31:ADDR_WIDTH+2], addr[1:0]};

  assign req = memread | memwrite;

`ifdef MISALIGN_TRAP_EN
  assign req_mis = (addr[1:0] != 2'b00);
`else
  assign req_mis = 1'b0;
`endif

  // With LATENCY == 1 the edge entering DONE is the acceptance edge, so the
  // read port must look at the live request rather than the latched one.
  assign rd_idx  = (state_reg == IDLE) ? addr[ADDR_WIDTH+1:2] : idx_reg;
  assign rd_load = (state_reg == IDLE) ? ~memwrite : ~store_reg;
  assign rd_mis  = (state_reg == IDLE) ? req_mis : mis_reg;

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    stall      = 1'b0;
    ready      = 1'b0;
    err        = 1'b0;
    case (state_reg)
      IDLE: begin
        if (req) begin
          stall      = 1'b1;
          cnt_next   = 4'(LATENCY - 1);
          state_next = (LATENCY > 1) ? BUSY : DONE;
        end
      end
      BUSY: begin
        stall    = 1'b1;
        cnt_next = cnt_reg - 4'd1;
        if (cnt_reg == 4'd1) state_next = DONE;
      end
      DONE: begin
        ready      = 1'b1;
        err        = err_reg;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
    // Reset dominates: the core sees no handshake activity while rst is high.
    if (rst) begin
      stall = 1'b0;
      ready = 1'b0;
      err   = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      idx_reg   <= '0;
      wdata_reg <= '0;
      store_reg <= 1'b0;
      err_reg   <= 1'b0;
      mis_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      if (state_reg == IDLE && req) begin
        idx_reg   <= addr[ADDR_WIDTH+1:2];
        wdata_reg <= wdata;
        store_reg <= memwrite;
        err_reg   <= (memread & memwrite) | req_mis;
        mis_reg   <= req_mis;
      end
    end
  end

  // Registered read port: loads land on the edge entering DONE.
  always_ff @(posedge clk) begin
    if (rst) begin
      rdata <= '0;
    end else if (state_next == DONE && state_reg != DONE && rd_load) begin
      rdata <= rd_mis ? '0 : mem[rd_idx];
    end
  end

  // Write port: stores commit on the DONE edge, so an aborted store never lands.
  always_ff @(posedge clk) begin
    if (!rst && state_reg == DONE && store_reg && !mis_reg) begin
      mem[idx_reg] <= wdata_reg;
    end
  end

endmodule
